dice_roll_display: RTL and testbench

//  Downstream consumer of the dice control stage. Takes its live 3-bit DiceValue,

---
 rtl/dice_roll_display.sv | 185 ++++++++++++++++++
 tb/tb_dice_roll_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_display.sv
// Purpose : debounce a roll button and run a roll/settle/freeze FSM over a live
//           dice value, driving a registered 7-LED pip display.
// Latency : Leds trail the held value by one clock.
//           Button edge to FSM reaction takes 2 + DEBOUNCE_CYCLES clocks.
// Backpress: none. DiceValue is sampled every clock.
//           An illegal value (0 or 7) locks the block in ERROR until nReset.
//
// Ports:
//   Clock     - system clock, all state on posedge
//   nReset    - asynchronous active-low reset
//   DiceValue - live dice value, legal 1..6
//   Button    - raw asynchronous roll button, 1 = pressed
//   Leds      - registered pip pattern (bit0 TL,1 TR,2 ML,3 C,4 MR,5 BL,6 BR)
//   Rolling   - 1 while rolling or settling
//   RollDone  - one-clock pulse when a roll freezes
//   RollCount - completed rolls, wraps at 255
//   Error     - sticky illegal-value flag
`timescale 1ns/1ps
module dice_roll_display #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_STEPS    = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [2:0] DiceValue,
    input  logic       Button,
    output logic [6:0] Leds,
    output logic       Rolling,
    output logic       RollDone,
    output logic [7:0] RollCount,
    output logic       Error
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = (SETTLE_STEPS > 0) ? $clog2(SETTLE_STEPS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROLLING = 2'd1,
        S_SETTLE  = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    function automatic logic [6:0] dice_pattern(input logic [2:0] v);
        logic [6:0] p;
        case (v)
            3'd1:    p = 7'h08;
            3'd2:    p = 7'h41;
            3'd3:    p = 7'h49;
            3'd4:    p = 7'h63;
            3'd5:    p = 7'h6B;
            3'd6:    p = 7'h77;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic          r_sync1, r_sync2;
    logic          r_db_level;
    logic [CW-1:0] r_db_cnt;
    state_t        r_state;
    logic [2:0]    r_held;
    logic [SW-1:0] r_steps;
    logic [6:0]    r_leds;
    logic          r_rolling;
    logic          r_roll_done;
    logic [7:0]    r_roll_count;
    logic          r_error;

    logic          w_db_flip;
    logic          w_press;
    logic          w_release;
    logic          w_illegal;
    state_t        w_state_nxt;
    logic [2:0]    w_held_nxt;
    logic [SW-1:0] w_steps_nxt;
    logic          w_done;

    // The debounced level flips on the clock that completes the run of
    // DEBOUNCE_CYCLES mismatches. Press/release are taken from that flip
    // directly, so the FSM reacts on the same clock as the debounced edge.
    assign w_db_flip = (r_sync2 != r_db_level) &&
                       (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_press   = w_db_flip &  r_sync2;
    assign w_release = w_db_flip & ~r_sync2;
    assign w_illegal = (DiceValue == 3'd0) || (DiceValue == 3'd7);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1 <= Button;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end
    end

    // Priority: illegal value, then press/release, then settle step.
    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_steps_nxt = r_steps;
        w_done      = 1'b0;
        if (w_illegal) begin
            w_state_nxt = S_ERROR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        w_state_nxt = S_ROLLING;
                    end
                end
                S_ROLLING: begin
                    w_held_nxt = DiceValue;
                    if (w_release) begin
                        if (SETTLE_STEPS == 0) begin
                            w_state_nxt = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt = S_SETTLE;
                            w_steps_nxt = SW'(SETTLE_STEPS);
                        end
                    end
                end
                S_SETTLE: begin
                    if (w_press) begin
                        w_state_nxt = S_ROLLING;
                    end else if (DiceValue != r_held) begin
                        w_held_nxt = DiceValue;
                        if (r_steps == SW'(1)) begin
                            w_steps_nxt = '0;
                            w_state_nxt = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_steps_nxt = r_steps - SW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= S_IDLE;
            r_held       <= 3'd1;
            r_steps      <= '0;
            r_leds       <= 7'h08;
            r_rolling    <= 1'b0;
            r_roll_done  <= 1'b0;
            r_roll_count <= 8'd0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_held       <= w_held_nxt;
            r_steps      <= w_steps_nxt;
            // Display blanks on the same clock the error is flagged.
            r_leds       <= (w_state_nxt == S_ERROR) ? 7'h00 : dice_pattern(r_held);
            r_rolling    <= (w_state_nxt == S_ROLLING) || (w_state_nxt == S_SETTLE);
            r_roll_done  <= w_done;
            r_roll_count <= r_roll_count + {7'd0, w_done};
            r_error      <= (w_state_nxt == S_ERROR);
        end
    end

    assign Leds      = r_leds;
    assign Rolling   = r_rolling;
    assign RollDone  = r_roll_done;
    assign RollCount = r_roll_count;
    assign Error     = r_error;

endmodule

// File: tb/tb_dice_roll_display.sv
`timescale 1ns/1ps
module tb_dice_roll_display;

    logic       Clock = 1'b0;
    logic       nReset;
    logic [2:0] DiceValue;
    logic       Button;
    logic [6:0] Leds;
    logic       Rolling;
    logic       RollDone;
    logic [7:0] RollCount;
    logic       Error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic [6:0] leds;
    } exp_t;

    exp_t sb_q[$];

    dice_roll_display #(.DEBOUNCE_CYCLES(16), .SETTLE_STEPS(4)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .DiceValue (DiceValue),
        .Button    (Button),
        .Leds      (Leds),
        .Rolling   (Rolling),
        .RollDone  (RollDone),
        .RollCount (RollCount),
        .Error     (Error)
    );

    always #5 Clock = ~Clock;

    // Hand-written pip table.
    function automatic logic [6:0] pip(input int v);
        case (v)
            1: return 7'h08;
            2: return 7'h41;
            3: return 7'h49;
            4: return 7'h63;
            5: return 7'h6B;
            6: return 7'h77;
            default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Monitor: every RollDone pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (nReset === 1'b1 && RollDone === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rolldone", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rolldone_count", {24'd0, RollCount}, {24'd0, e.cnt});
                    @(negedge Clock);
                    chk("rolldone_pulse_width", {31'd0, RollDone}, 32'd0);
                    chk("frozen_leds", {25'd0, Leds}, {25'd0, e.leds});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic saw_rolling;
        nReset    = 1'b0;
        DiceValue = 3'd3;
        Button    = 1'b0;
        tick(3);
        chk("reset_leds",     {25'd0, Leds},      32'h08);
        chk("reset_rolling",  {31'd0, Rolling},   32'd0);
        chk("reset_rolldone", {31'd0, RollDone},  32'd0);
        chk("reset_count",    {24'd0, RollCount}, 32'd0);
        chk("reset_error",    {31'd0, Error},     32'd0);
        nReset = 1'b1;
        tick(30);
        chk("idle_leds",    {25'd0, Leds},      32'h08);
        chk("idle_rolling", {31'd0, Rolling},   32'd0);
        chk("idle_count",   {24'd0, RollCount}, 32'd0);

        // Glitch one clock short of the debounce window.
        saw_rolling = 1'b0;
        Button = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            saw_rolling |= Rolling;
        end
        Button = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            saw_rolling |= Rolling;
        end
        chk("glitch_ignored", {31'd0, saw_rolling}, 32'd0);

        // Press: Rolling rises exactly 18 clocks after the raw edge.
        Button = 1'b1;
        tick(17);
        chk("press_rolling_early", {31'd0, Rolling}, 32'd0);
        tick(1);
        chk("press_rolling_18", {31'd0, Rolling}, 32'd1);
        for (int v = 1; v <= 6; v++) begin
            DiceValue = 3'(v);
            tick(1);
            tick(1);
            chk($sformatf("track_leds_%0d", v), {25'd0, Leds}, {25'd0, pip(v)});
        end

        // Release then settle across 2,5,4,6; freeze on the 6.
        Button = 1'b0;
        tick(18);
        chk("settle_rolling", {31'd0, Rolling}, 32'd1);
        sb_q.push_back('{cnt: 8'd1, leds: 7'h77});
        DiceValue = 3'd2; tick(2);
        DiceValue = 3'd5; tick(2);
        DiceValue = 3'd4; tick(2);
        DiceValue = 3'd6; tick(2);
        chk("frozen_rolling", {31'd0, Rolling}, 32'd0);
        DiceValue = 3'd1; tick(3);
        DiceValue = 3'd2; tick(3);
        chk("frozen_hold_leds", {25'd0, Leds},      32'h77);
        chk("frozen_count",     {24'd0, RollCount}, 32'd1);

        // Re-press during settle after two steps: back to rolling, no count.
        Button = 1'b1;
        tick(18);
        chk("roll2_rolling", {31'd0, Rolling}, 32'd1);
        Button = 1'b0;
        tick(18);
        DiceValue = 3'd3; tick(2);
        DiceValue = 3'd5; tick(2);
        Button = 1'b1;
        tick(18);
        chk("repress_rolling", {31'd0, Rolling},   32'd1);
        chk("repress_count",   {24'd0, RollCount}, 32'd1);

        // Illegal value while rolling.
        DiceValue = 3'd7;
        tick(1);
        chk("err_flag",    {31'd0, Error},   32'd1);
        chk("err_leds",    {25'd0, Leds},    32'h00);
        chk("err_rolling", {31'd0, Rolling}, 32'd0);
        DiceValue = 3'd4;
        Button = 1'b0;
        tick(20);
        Button = 1'b1;
        tick(20);
        chk("err_sticky",      {31'd0, Error},     32'd1);
        chk("err_btn_ignored", {31'd0, Rolling},   32'd0);
        chk("err_leds_hold",   {25'd0, Leds},      32'h00);
        chk("err_count_hold",  {24'd0, RollCount}, 32'd1);

        // Asynchronous reset clears everything immediately.
        nReset = 1'b0;
        #1;
        chk("arst_leds",  {25'd0, Leds},      32'h08);
        chk("arst_error", {31'd0, Error},     32'd0);
        chk("arst_count", {24'd0, RollCount}, 32'd0);
        chk("arst_roll",  {31'd0, Rolling},   32'd0);
        Button = 1'b0;
        DiceValue = 3'd3;
        tick(2);
        nReset = 1'b1;
        tick(25);
        chk("post_reset_leds",  {25'd0, Leds},    32'h08);
        chk("post_reset_roll",  {31'd0, Rolling}, 32'd0);
        chk("post_reset_error", {31'd0, Error},   32'd0);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
